// File: rtl/audio_pkg.sv
// Shared definitions for the alarm sequencer: state encoding, tone table
// and the fixed counter widths.
package audio_pkg;

  localparam int SEL_W  = 2;   // tone-select width
  localparam int HALF_W = 6;   // half-period counter width (max entry is 40)
  localparam int REP_W  = 4;   // beep counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TONO  = 2'd1,
    PAUSA = 2'd2
  } estado_e;

  // Half-period of each tone, counted in audio samples.
  function automatic logic [HALF_W-1:0] half_period(input logic [SEL_W-1:0] sel);
    logic [HALF_W-1:0] h;
    case (sel)
      2'd0:    h = 6'd40;  // 500 Hz
      2'd1:    h = 6'd20;  // 1 kHz
      2'd2:    h = 6'd10;  // 2 kHz
      default: h = 6'd5;   // 4 kHz
    endcase
    return h;
  endfunction

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divisor_muestra.sv
// Sample-rate tick generator: one-cycle tick every SAMPLE_DIV clocks,
// restarted from zero by a synchronous clear.
import audio_pkg::*;

module divisor_muestra #(
  parameter int SAMPLE_DIV = 2500
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV_W = cnt_width(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Tick is decoded from the register so it carries no combinational input path.
  assign tick = (cnt_q == DIV_LAST);

  // Next count: clear wins, then reload on terminal count, else increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)     cnt_d = '0;
    else if (tick) cnt_d = '0;
    else           cnt_d = cnt_q + DIV_W'(1);
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/secuenciador_alarma.sv
// Alarm beep sequencer: plays rep beeps of a square-wave tone separated by
// silent pauses and feeds the PWM packer sample bus.
import audio_pkg::*;

module secuenciador_alarma #(
  parameter int          SAMPLE_DIV  = 2500,
  parameter int          ON_SAMPLES  = 8000,
  parameter int          OFF_SAMPLES = 8000,
  parameter logic [7:0]  AMPL        = 8'd200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [SEL_W-1:0] tono_sel,
  input  logic [REP_W-1:0] rep,
  output logic             act_sonido,
  output logic [7:0]       data_out,
  output logic             busy,
  output logic             done
);

  localparam int DUR_MAX = (ON_SAMPLES > OFF_SAMPLES) ? ON_SAMPLES : OFF_SAMPLES;
  localparam int DUR_W   = cnt_width(DUR_MAX);
  localparam logic [DUR_W-1:0] ON_LAST  = DUR_W'(ON_SAMPLES - 1);
  localparam logic [DUR_W-1:0] OFF_LAST = DUR_W'(OFF_SAMPLES - 1);

  estado_e           estado_q, estado_d;
  logic [SEL_W-1:0]  sel_q,    sel_d;
  logic [REP_W-1:0]  beeps_q,  beeps_d;
  logic [DUR_W-1:0]  dur_q,    dur_d;
  logic [HALF_W-1:0] half_q,   half_d;
  logic              fase_q,   fase_d;
  logic              done_d;

  logic              act_q;
  logic [7:0]        data_q;
  logic              busy_q;
  logic              done_q;

  logic              tick;
  logic              div_clr;

  // The divider restarts at zero on every state entry and is held while idle,
  // so the first tick of each phase lands SAMPLE_DIV-1 cycles after entry.
  assign div_clr = (estado_d != estado_q) || (estado_q == IDLE);

  divisor_muestra #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (div_clr),
    .tick  (tick)
  );

  // Next state and counters; stop is evaluated before any tick-driven change.
  always_comb begin
    estado_d = estado_q;
    sel_d    = sel_q;
    beeps_d  = beeps_q;
    dur_d    = dur_q;
    half_d   = half_q;
    fase_d   = fase_q;
    done_d   = 1'b0;

    unique case (estado_q)
      IDLE: begin
        if (start && (rep != '0)) begin
          estado_d = TONO;
          sel_d    = tono_sel;
          beeps_d  = rep;
          dur_d    = '0;
          half_d   = '0;
          fase_d   = 1'b1;
        end
      end

      TONO: begin
        if (stop) begin
          estado_d = IDLE;
          beeps_d  = '0;
          dur_d    = '0;
          half_d   = '0;
          fase_d   = 1'b0;
        end else if (tick) begin
          // Tone phase: flip on the last sample of each half-period.
          if (half_q == half_period(sel_q) - 6'd1) begin
            half_d = '0;
            fase_d = ~fase_q;
          end else begin
            half_d = half_q + 6'd1;
          end
          // Beep length: leave the tone on its last sample.
          if (dur_q == ON_LAST) begin
            dur_d  = '0;
            half_d = '0;
            fase_d = 1'b0;
            if (beeps_q > 4'd1) begin
              estado_d = PAUSA;
              beeps_d  = beeps_q - 4'd1;
            end else begin
              estado_d = IDLE;
              beeps_d  = '0;
              done_d   = 1'b1;
            end
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
      end

      PAUSA: begin
        if (stop) begin
          estado_d = IDLE;
          beeps_d  = '0;
          dur_d    = '0;
          half_d   = '0;
          fase_d   = 1'b0;
        end else if (tick) begin
          if (dur_q == OFF_LAST) begin
            estado_d = TONO;
            dur_d    = '0;
            half_d   = '0;
            fase_d   = 1'b1;   // every beep restarts on the high phase
          end else begin
            dur_d = dur_q + DUR_W'(1);
          end
        end
      end

      default: begin
        estado_d = IDLE;
        beeps_d  = '0;
        dur_d    = '0;
        half_d   = '0;
        fase_d   = 1'b0;
      end
    endcase
  end

  // State, latched pattern and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= IDLE;
      sel_q    <= '0;
      beeps_q  <= '0;
      dur_q    <= '0;
      half_q   <= '0;
      fase_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sel_q    <= sel_d;
      beeps_q  <= beeps_d;
      dur_q    <= dur_d;
      half_q   <= half_d;
      fase_q   <= fase_d;
    end
  end

  // Registered outputs decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q  <= 1'b0;
      data_q <= 8'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      act_q  <= (estado_d == TONO);
      data_q <= ((estado_d == TONO) && fase_d) ? AMPL : 8'd0;
      busy_q <= (estado_d != IDLE);
      done_q <= done_d;
    end
  end

  assign act_sonido = act_q;
  assign data_out   = data_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_secuenciador_alarma.sv
// Self-checking bench for secuenciador_alarma with a timeline reference model.
module tb_secuenciador_alarma;

  localparam int         D   = 4;
  localparam int         ON  = 8;
  localparam int         OFF = 4;
  localparam logic [7:0] AMP = 8'd200;

  logic       clk = 1'b0;
  logic       reset, start, stop;
  logic [1:0] tono_sel;
  logic [3:0] rep;
  logic       act_sonido, busy, done;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: cycle offset k since the start was sampled (k=1 first busy cycle).
  bit m_busy = 1'b0;
  int m_k, m_sel, m_rep;
  int done_cnt = 0;
  int half_tbl [4] = '{40, 20, 10, 5};

  always #5 clk = ~clk;

  secuenciador_alarma #(
    .SAMPLE_DIV  (D),
    .ON_SAMPLES  (ON),
    .OFF_SAMPLES (OFF),
    .AMPL        (AMP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .tono_sel   (tono_sel),
    .rep        (rep),
    .act_sonido (act_sonido),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Advance the model with the inputs the DUT just sampled.
  task automatic model_update();
    if (reset)       m_busy = 1'b0;
    else if (m_busy) begin
      if (stop) m_busy = 1'b0;
      else      m_k++;
    end else if (start && rep != 0) begin
      m_busy = 1'b1;
      m_k    = 1;
      m_sel  = tono_sel;
      m_rep  = rep;
    end
  endtask

  // Expected outputs from the pattern timeline, then compare.
  task automatic compare();
    int e_act, e_data, e_busy, e_done;
    int per, mm, r;
    e_act = 0; e_data = 0; e_busy = 0; e_done = 0;
    if (m_busy) begin
      per = (ON + OFF) * D;
      if (m_k == m_rep * per - OFF * D + 1) begin
        e_done = 1;
        m_busy = 1'b0;
      end else begin
        mm     = m_k - 1;
        r      = mm % per;
        e_busy = 1;
        e_act  = (r < ON * D) ? 1 : 0;
        if (e_act == 1 && ((r / (half_tbl[m_sel] * D)) % 2) == 0) e_data = AMP;
      end
    end
    check("act_sonido", 32'(act_sonido), e_act);
    check("data_out",   32'(data_out),   e_data);
    check("busy",       32'(busy),       e_busy);
    check("done",       32'(done),       e_done);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    compare();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_start(input int s, input int r);
    tono_sel = 2'(s);
    rep      = 4'(r);
    start    = 1'b1;
    step();
  endtask

  int d0;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; tono_sel = 2'd0; rep = 4'd0;

    // Reset held, then idle with no start.
    run(3);
    reset = 1'b0;
    run(6);

    // Single 4 kHz beep.
    d0 = done_cnt;
    do_start(3, 1);
    run(40);
    check("done_count_rep1", done_cnt - d0, 1);

    // Two beeps with a pause.
    d0 = done_cnt;
    do_start(3, 2);
    run(90);
    check("done_count_rep2", done_cnt - d0, 1);

    // Stop during the first beep.
    d0 = done_cnt;
    do_start(3, 3);
    run(9);
    stop = 1'b1;
    step();
    run(5);
    check("busy_after_stop", 32'(busy), 0);
    check("done_count_stop", done_cnt - d0, 0);

    // Stop on the same cycle as the final tick.
    d0 = done_cnt;
    do_start(3, 1);
    while (m_busy && m_k < 32) step();
    stop = 1'b1;
    step();
    run(5);
    check("done_count_stop_last", done_cnt - d0, 0);

    // Start with rep=0 does nothing.
    do_start(2, 0);
    run(5);
    check("busy_rep0", 32'(busy), 0);

    // Second start mid-pattern ignored.
    d0 = done_cnt;
    do_start(3, 2);
    run(10);
    do_start(0, 5);
    run(100);
    check("done_count_restart", done_cnt - d0, 1);

    // Reset during the pause, then a clean two-beep pattern.
    do_start(3, 2);
    while (m_busy && m_k < 40) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(3);
    d0 = done_cnt;
    do_start(3, 2);
    run(90);
    check("done_count_after_reset", done_cnt - d0, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      tono_sel = 2'($urandom_range(0, 3));
      rep      = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      start    = ($urandom_range(0, 19) == 0);
      stop     = ($urandom_range(0, 299) == 0);
      reset    = ($urandom_range(0, 799) == 0);
      step();
      reset = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
